// File: rtl/me_io_bridge.sv
// Pad-ring bridge for the ME core: fetch pipes, result FIFO, serialiser.
// Build option ME_IO_PARITY_EN appends an even-parity bit to each frame.
module me_io_bridge #(
  parameter int REF_W      = 64,
  parameter int CUR_W      = 32,
  parameter int SAD_W      = 16,
  parameter int MV_W       = 8,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REF_W-1:0] pad_ref_in,
  input  logic [CUR_W-1:0] pad_cur_in,
  input  logic             core_ref_read,
  input  logic             core_cur_read,
  output logic             pad_ref_read,
  output logic             pad_cur_read,
  output logic [REF_W-1:0] core_ref_data,
  output logic             core_ref_valid,
  output logic [CUR_W-1:0] core_cur_data,
  output logic             core_cur_valid,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [SAD_W-1:0] res_sad,
  input  logic [MV_W-1:0]  res_x,
  input  logic [MV_W-1:0]  res_y,
  output logic [LANES-1:0] ser_data,
  output logic             ser_sync
);
  localparam int F = SAD_W + 2 * MV_W;
`ifdef ME_IO_PARITY_EN
  localparam int FL = F + 1;
`else
  localparam int FL = F;
`endif
  localparam int B    = (FL + LANES - 1) / LANES;
  localparam int SW   = B * LANES;
  localparam int PADW = SW - FL;
  localparam int CW   = (B > 1) ? $clog2(B) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int OW   = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  logic             ref_rd_q, ref_rd_d;
  logic             ref_cap_q, ref_cap_d;
  logic             ref_vld_q, ref_vld_d;
  logic [REF_W-1:0] ref_dat_q, ref_dat_d;
  logic             cur_rd_q, cur_rd_d;
  logic             cur_cap_q, cur_cap_d;
  logic             cur_vld_q, cur_vld_d;
  logic [CUR_W-1:0] cur_dat_q, cur_dat_d;

  // Capture happens the cycle after the pad strobe, when memory drives data.
  always_comb begin
    ref_rd_d  = core_ref_read;
    ref_cap_d = ref_rd_q;
    ref_vld_d = ref_cap_q;
    ref_dat_d = ref_cap_q ? pad_ref_in : ref_dat_q;
    cur_rd_d  = core_cur_read;
    cur_cap_d = cur_rd_q;
    cur_vld_d = cur_cap_q;
    cur_dat_d = cur_cap_q ? pad_cur_in : cur_dat_q;
  end

  logic [F-1:0]  mem_q [FIFO_DEPTH];
  logic [F-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;
  logic [F-1:0]  head;

  assign full      = (cnt_q == OW'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign res_ready = !full;
  assign push      = res_valid && !full;
  assign head      = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = {res_sad, res_x, res_y};
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + OW'(1);
      2'b01:   cnt_d = cnt_q - OW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  logic [FL-1:0] frame;
`ifdef ME_IO_PARITY_EN
  assign frame = {head, ^head};
`else
  assign frame = head;
`endif

  logic [SW-1:0] sr_init;
  assign sr_init = SW'(frame) << PADW;

  state_e           st_q, st_d;
  logic [SW-1:0]    sr_q, sr_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic [LANES-1:0] sd_q, sd_d;
  logic             sync_q, sync_d;
  logic             last;

  assign last = (beat_q == CW'(B - 1));

  // Output regs hold the beat on the wire; sr holds the beats still to go.
  always_comb begin
    st_d   = st_q;
    sr_d   = sr_q;
    beat_d = beat_q;
    sd_d   = '0;
    sync_d = 1'b0;
    pop    = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          sd_d   = sr_init[SW-1 -: LANES];
          sr_d   = sr_init << LANES;
          beat_d = '0;
          sync_d = 1'b1;
          st_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!last) begin
          sd_d   = sr_q[SW-1 -: LANES];
          sr_d   = sr_q << LANES;
          beat_d = beat_q + CW'(1);
        end else if (!empty) begin
          pop    = 1'b1;
          sd_d   = sr_init[SW-1 -: LANES];
          sr_d   = sr_init << LANES;
          beat_d = '0;
          sync_d = 1'b1;
        end else begin
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_rd_q  <= 1'b0;
      ref_cap_q <= 1'b0;
      ref_vld_q <= 1'b0;
      ref_dat_q <= '0;
      cur_rd_q  <= 1'b0;
      cur_cap_q <= 1'b0;
      cur_vld_q <= 1'b0;
      cur_dat_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      st_q      <= IDLE;
      sr_q      <= '0;
      beat_q    <= '0;
      sd_q      <= '0;
      sync_q    <= 1'b0;
    end else begin
      ref_rd_q  <= ref_rd_d;
      ref_cap_q <= ref_cap_d;
      ref_vld_q <= ref_vld_d;
      ref_dat_q <= ref_dat_d;
      cur_rd_q  <= cur_rd_d;
      cur_cap_q <= cur_cap_d;
      cur_vld_q <= cur_vld_d;
      cur_dat_q <= cur_dat_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      st_q      <= st_d;
      sr_q      <= sr_d;
      beat_q    <= beat_d;
      sd_q      <= sd_d;
      sync_q    <= sync_d;
    end
  end

  assign pad_ref_read   = ref_rd_q;
  assign pad_cur_read   = cur_rd_q;
  assign core_ref_data  = ref_dat_q;
  assign core_ref_valid = ref_vld_q;
  assign core_cur_data  = cur_dat_q;
  assign core_cur_valid = cur_vld_q;
  assign ser_data       = sd_q;
  assign ser_sync       = sync_q;
endmodule

// File: tb/tb_me_io_bridge.sv
// Directed bench for me_io_bridge: fetch table, serial frames, reset, backpressure.
// Three instances cover LANES = 1, 4 and 5.
module tb_me_io_bridge;
`ifdef ME_IO_PARITY_EN
  localparam int FL = 33;
  localparam logic [32:0] EXP_ORD  = 33'h1_0002_FF00;
  localparam logic [32:0] EXP_ONE  = 33'h0_0002_0001;
  localparam logic [32:0] EXP_C    = 33'h1_874A_1FE0;
  localparam logic [32:0] EXP_SYNC = 33'h1_0000_0000;
`else
  localparam int FL = 32;
  localparam logic [32:0] EXP_ORD  = 33'h0_8001_7F80;
  localparam logic [32:0] EXP_ONE  = 33'h0_0001_0000;
  localparam logic [32:0] EXP_C    = 33'h0_C3A5_0FF0;
  localparam logic [32:0] EXP_SYNC = 33'h0_8000_0000;
`endif
  localparam int B4 = (FL + 3) / 4;
  localparam int B5 = (FL + 4) / 5;
  localparam int NBP = 2 + 6 * B4 + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        core_ref_read, core_cur_read;
  logic [63:0] pad_ref_in;
  logic [31:0] pad_cur_in;

  logic        prr1, pcr1, rval1, cval1, prr4, pcr4, rval4, cval4;
  logic        prr5, pcr5, rval5, cval5;
  logic [63:0] rdat1, rdat4, rdat5;
  logic [31:0] cdat1, cdat4, cdat5;

  logic        rv1, rv4, rv5, rdy1, rdy4, rdy5, ss1, ss4, ss5;
  logic [15:0] sad1, sad4, sad5;
  logic [7:0]  x1, x4, x5, y1, y4, y5;
  logic [0:0]  sd1;
  logic [3:0]  sd4;
  logic [4:0]  sd5;

  me_io_bridge #(.LANES(1)) u1 (
    .clk(clk), .rst(rst), .pad_ref_in(pad_ref_in), .pad_cur_in(pad_cur_in),
    .core_ref_read(core_ref_read), .core_cur_read(core_cur_read),
    .pad_ref_read(prr1), .pad_cur_read(pcr1),
    .core_ref_data(rdat1), .core_ref_valid(rval1),
    .core_cur_data(cdat1), .core_cur_valid(cval1),
    .res_valid(rv1), .res_ready(rdy1), .res_sad(sad1), .res_x(x1), .res_y(y1),
    .ser_data(sd1), .ser_sync(ss1));

  me_io_bridge #(.LANES(4)) u4 (
    .clk(clk), .rst(rst), .pad_ref_in(pad_ref_in), .pad_cur_in(pad_cur_in),
    .core_ref_read(core_ref_read), .core_cur_read(core_cur_read),
    .pad_ref_read(prr4), .pad_cur_read(pcr4),
    .core_ref_data(rdat4), .core_ref_valid(rval4),
    .core_cur_data(cdat4), .core_cur_valid(cval4),
    .res_valid(rv4), .res_ready(rdy4), .res_sad(sad4), .res_x(x4), .res_y(y4),
    .ser_data(sd4), .ser_sync(ss4));

  me_io_bridge #(.LANES(5)) u5 (
    .clk(clk), .rst(rst), .pad_ref_in(pad_ref_in), .pad_cur_in(pad_cur_in),
    .core_ref_read(core_ref_read), .core_cur_read(core_cur_read),
    .pad_ref_read(prr5), .pad_cur_read(pcr5),
    .core_ref_data(rdat5), .core_ref_valid(rval5),
    .core_cur_data(cdat5), .core_cur_valid(cval5),
    .res_valid(rv5), .res_ready(rdy5), .res_sad(sad5), .res_x(x5), .res_y(y5),
    .ser_data(sd5), .ser_sync(ss5));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected lanes of beat k: payload MSB first, earliest bit on top lane.
  function automatic logic [7:0] exp_beat(input logic [31:0] pl,
                                          input int lanes, input int k);
    logic [32:0] fr;
    logic [7:0]  r;
    int          p;
    r = '0;
`ifdef ME_IO_PARITY_EN
    fr = {pl, ^pl};
`else
    fr = {1'b0, pl};
`endif
    for (int l = 0; l < lanes; l++) begin
      p = k * lanes + (lanes - 1 - l);
      if (p < FL) r[l] = fr[FL-1-p];
    end
    return r;
  endfunction

  task automatic send1(input logic [15:0] s, input logic [7:0] x,
                       input logic [7:0] y, output logic [32:0] gb,
                       output logic [32:0] gs);
    rv1 = 1'b1; sad1 = s; x1 = x; y1 = y;
    tick();
    rv1 = 1'b0;
    tick();
    gb = '0;
    gs = '0;
    for (int k = 0; k < FL; k++) begin
      gb = {gb[31:0], sd1[0]};
      gs = {gs[31:0], ss1};
      tick();
    end
  endtask

  typedef struct {
    logic        rr, cr;
    logic [63:0] ri;
    logic [31:0] ci;
    logic        prr, pcr, rv;
    logic [63:0] rd;
    logic        cv;
    logic [31:0] cd;
  } fvec_t;

  fvec_t       tbl [12];
  logic [31:0] bpv [6];
  int          acc [6];
  logic [3:0]  obs_d [NBP];
  logic        obs_s [NBP];
  logic        obs_r [NBP];

  initial begin
    logic [32:0] gb, gs;
    logic [31:0] pl;
    logic [7:0]  eb;
    int          idx, rel;

    for (int i = 0; i < 12; i++)
      tbl[i] = '{1'b0, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 32'hDEAD_BEEF,
                 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0};
    tbl[5].rr = 1'b1;  tbl[5].cr = 1'b1;
    tbl[6].rr = 1'b1;  tbl[6].prr = 1'b1; tbl[6].pcr = 1'b1;
    tbl[7].rr = 1'b1;  tbl[7].cr = 1'b1;  tbl[7].prr = 1'b1;
    tbl[7].ri = 64'hA5A5_A5A5_A5A5_A5A5;  tbl[7].ci = 32'h1234_5678;
    tbl[8].prr = 1'b1; tbl[8].pcr = 1'b1;
    tbl[8].ri = 64'h5A5A_5A5A_5A5A_5A5A;
    tbl[8].rv = 1'b1;  tbl[8].rd = 64'hA5A5_A5A5_A5A5_A5A5;
    tbl[8].cv = 1'b1;  tbl[8].cd = 32'h1234_5678;
    tbl[9].ri = 64'hFFFF_FFFF_FFFF_FFFF;  tbl[9].ci = 32'hCAFE_F00D;
    tbl[9].rv = 1'b1;  tbl[9].rd = 64'h5A5A_5A5A_5A5A_5A5A;
    tbl[9].cd = 32'h1234_5678;
    tbl[10].rv = 1'b1; tbl[10].rd = 64'hFFFF_FFFF_FFFF_FFFF;
    tbl[10].cv = 1'b1; tbl[10].cd = 32'hCAFE_F00D;
    tbl[11].rd = 64'hFFFF_FFFF_FFFF_FFFF; tbl[11].cd = 32'hCAFE_F00D;

    bpv[0] = 32'h1111_01F1; bpv[1] = 32'h2222_02E2; bpv[2] = 32'h3333_03D3;
    bpv[3] = 32'h4444_04C4; bpv[4] = 32'h5555_05B5; bpv[5] = 32'h6666_06A6;

    rst = 1'b1;
    core_ref_read = 1'b0; core_cur_read = 1'b0;
    pad_ref_in = '0; pad_cur_in = '0;
    rv1 = 1'b0; rv4 = 1'b0; rv5 = 1'b0;
    sad1 = '0; sad4 = '0; sad5 = '0;
    x1 = '0; x4 = '0; x5 = '0; y1 = '0; y4 = '0; y5 = '0;
    tick(); tick();
    chk("rst_ready1", rdy1, 1);
    chk("rst_ready4", rdy4, 1);
    chk("rst_ser1", {ss1, sd1}, 0);
    chk("rst_ser5", {ss5, sd5}, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("c%0d_pad_ref_read", i), prr1, tbl[i].prr);
      chk($sformatf("c%0d_pad_cur_read", i), pcr1, tbl[i].pcr);
      chk($sformatf("c%0d_ref_valid", i), rval1, tbl[i].rv);
      chk($sformatf("c%0d_ref_data", i), rdat1, tbl[i].rd);
      chk($sformatf("c%0d_cur_valid", i), cval1, tbl[i].cv);
      chk($sformatf("c%0d_cur_data", i), cdat1, tbl[i].cd);
      core_ref_read = tbl[i].rr;
      core_cur_read = tbl[i].cr;
      pad_ref_in    = tbl[i].ri;
      pad_cur_in    = tbl[i].ci;
      tick();
    end
    core_ref_read = 1'b0;
    core_cur_read = 1'b0;
    tick(); tick();

    send1(16'h8001, 8'h7F, 8'h80, gb, gs);
    chk("ser_order", gb, EXP_ORD);
    chk("ser_order_sync", gs, EXP_SYNC);
    chk("ser_order_idle", {ss1, sd1}, 0);
    send1(16'h0001, 8'h00, 8'h00, gb, gs);
    chk("ser_one", gb, EXP_ONE);
    send1(16'h0000, 8'h00, 8'h00, gb, gs);
    chk("ser_zero", gb, 0);
    chk("ser_zero_sync", gs, EXP_SYNC);

    // Reset during beat 10 of a frame with a second result queued.
    rv1 = 1'b1; sad1 = 16'hFFFF; x1 = 8'hFF; y1 = 8'hFF;
    tick();
    sad1 = 16'h1234; x1 = 8'h56; y1 = 8'h78;
    tick();
    rv1 = 1'b0;
    chk("mid_beat0_sync", ss1, 1);
    repeat (10) tick();
    chk("mid_beat10", sd1, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", sd1, 0);
    chk("mid_rst_sync", ss1, 0);
    chk("mid_rst_ready", rdy1, 1);
    tick();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("post_rst_idle%0d", j), {ss1, sd1}, 0);
    end
    send1(16'hC3A5, 8'h0F, 8'hF0, gb, gs);
    chk("post_rst_frame", gb, EXP_C);
    chk("post_rst_sync", gs, EXP_SYNC);
    chk("post_rst_end", {ss1, sd1}, 0);

    pl = 32'hA5C3_963B;
    rv5 = 1'b1; sad5 = pl[31:16]; x5 = pl[15:8]; y5 = pl[7:0];
    tick();
    rv5 = 1'b0;
    tick();
    for (int k = 0; k < B5; k++) begin
      eb = exp_beat(pl, 5, k);
      chk($sformatf("l5_beat%0d", k), sd5, eb[4:0]);
      chk($sformatf("l5_sync%0d", k), ss5, (k == 0) ? 1 : 0);
      if (k == 0) chk("l5_beat0_hand", sd5, 5'b10100);
`ifndef ME_IO_PARITY_EN
      if (k == 6) chk("l5_beat6_hand", sd5, 5'b11000);
`endif
      tick();
    end
    chk("l5_idle", {ss5, sd5}, 0);

    idx = 0;
    for (int c = 0; c < NBP; c++) begin
      obs_d[c] = sd4;
      obs_s[c] = ss4;
      obs_r[c] = rdy4;
      if (idx < 6) begin
        rv4 = 1'b1;
        {sad4, x4, y4} = bpv[idx];
        if (rdy4) begin
          acc[idx] = c;
          idx++;
        end
      end else begin
        rv4 = 1'b0;
      end
      tick();
    end
    rv4 = 1'b0;
    chk("bp_all_accepted", idx, 6);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_acc%0d", i), acc[i], i);
    chk("bp_acc5", acc[5], 2 + B4);
    chk("bp_ready_low", obs_r[5], 0);
    chk("bp_ready_back", obs_r[2 + B4], 1);
    for (int c = 0; c < NBP; c++) begin
      rel = c - 2;
      if (rel >= 0 && rel < 6 * B4) begin
        eb = exp_beat(bpv[rel / B4], 4, rel % B4);
        chk($sformatf("bp_data%0d", c), obs_d[c], eb[3:0]);
        chk($sformatf("bp_sync%0d", c), obs_s[c], (rel % B4 == 0) ? 1 : 0);
      end else begin
        chk($sformatf("bp_data%0d", c), obs_d[c], 0);
        chk($sformatf("bp_sync%0d", c), obs_s[c], 0);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
